fpu_issue_ctrl: RTL and testbench

//  Multi-channel front end for the fpu core. Takes requests from NCH independent

---
 rtl/fpu_issue_ctrl_if.sv | 30 +++
 rtl/fpu_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response bundle between the bus agents and fpu_issue_ctrl.
// The master drives the requests and consumes the responses; the slave is the controller.
interface fpu_issue_ctrl_if #(
    parameter int NCH = 2
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [3*NCH-1:0]  req_op;
    logic [2*NCH-1:0]  req_rmode;
    logic [32*NCH-1:0] req_opa;
    logic [32*NCH-1:0] req_opb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [CW-1:0]     rsp_ch;
    logic [31:0]       rsp_out;
    logic [7:0]        rsp_flags;

    modport master (
        output req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
        input  req_ready, rsp_valid, rsp_ch, rsp_out, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_rmode, req_opa, req_opb, rsp_ready,
        output req_ready, rsp_valid, rsp_ch, rsp_out, rsp_flags
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Round-robin multi-channel issue front end for the fixed-latency fpu core, with tagged
// credit-controlled response FIFO. Define FPU_ISSUE_STATS_EN to add issue/retire/stall counters.
module fpu_issue_ctrl #(
    parameter int NCH     = 2,
    parameter int FPU_LAT = 4,
    parameter int RDEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    fpu_issue_ctrl_if.slave    bus,
    output logic [2:0]         fpu_op,
    output logic [1:0]         rmode,
    output logic [31:0]        opa,
    output logic [31:0]        opb,
    input  logic [31:0]        fpu_out,
    input  logic [7:0]         fpu_flags
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_retired,
    output logic [31:0]        stat_stall
`endif
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW   = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int CNTW = $clog2(RDEPTH) + 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [31:0]   out;
        logic [7:0]    flags;
    } rsp_t;

    logic [CW-1:0]   rr_ptr;
    logic [CNTW-1:0] credit;
    logic [NCH-1:0]  grant;
    logic [CW-1:0]   win;
    logic            found;
    logic            accept;
    logic [2:0]      sel_op;
    logic [1:0]      sel_rmode;
    logic [31:0]     sel_opa;
    logic [31:0]     sel_opb;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        // Two passes: channels at/after the pointer first, then the wrapped-around ones.
        for (int j = 0; j < NCH; j++) begin
            if (!found && bus.req_valid[j] && j >= int'(rr_ptr)) begin
                grant[j] = 1'b1;
                win      = CW'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!found && bus.req_valid[j] && j < int'(rr_ptr)) begin
                grant[j] = 1'b1;
                win      = CW'(j);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_rmode = '0;
        sel_opa   = '0;
        sel_opb   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (grant[j]) begin
                sel_op    = bus.req_op[3*j +: 3];
                sel_rmode = bus.req_rmode[2*j +: 2];
                sel_opa   = bus.req_opa[32*j +: 32];
                sel_opb   = bus.req_opb[32*j +: 32];
            end
        end
    end

    assign bus.req_ready = grant & {NCH{(credit != '0) & ~rst}};
    assign accept        = |bus.req_ready;

    logic [FPU_LAT-1:0] tag_v;
    logic [CW-1:0]      tag_ch [FPU_LAT];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            fpu_op <= '0;
            rmode  <= '0;
            opa    <= '0;
            opb    <= '0;
            tag_v  <= '0;
            for (int k = 0; k < FPU_LAT; k++) tag_ch[k] <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
                fpu_op <= sel_op;
                rmode  <= sel_rmode;
                opa    <= sel_opa;
                opb    <= sel_opb;
            end
            tag_v[0]  <= accept;
            tag_ch[0] <= win;
            for (int k = 1; k < FPU_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_ch[k] <= tag_ch[k-1];
            end
        end
    end

    rsp_t            mem [RDEPTH];
    rsp_t            head;
    rsp_t            push_d;
    logic            head_valid;
    logic            push;
    logic            pop;
    logic            full;
    logic            head_bypass;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [CNTW-1:0] fcnt;
    logic [CNTW-1:0] fcnt_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (RDEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    assign push        = tag_v[FPU_LAT-1];
    assign push_d      = {tag_ch[FPU_LAT-1], fpu_out, fpu_flags};
    assign pop         = head_valid & bus.rsp_ready;
    assign full        = (fcnt == CNTW'(RDEPTH));
    assign rd_nxt      = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign fcnt_nxt    = fcnt + CNTW'(push) - CNTW'(pop);
    // The entry being pushed becomes the next head when nothing else remains queued.
    assign head_bypass = (fcnt == CNTW'(pop));

    // NOTE: the FIFO storage has no reset; the head register and the count carry all reset state.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcnt       <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            credit     <= CNTW'(RDEPTH);
        end else begin
            assert (!(push && full && !pop));
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr     <= rd_nxt;
            fcnt       <= fcnt_nxt;
            head_valid <= (fcnt_nxt != '0);
            if (fcnt_nxt != '0) head <= head_bypass ? push_d : mem[rd_nxt];
            case ({accept, pop})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    assign bus.rsp_valid = head_valid;
    assign bus.rsp_ch    = head.ch;
    assign bus.rsp_out   = head.out;
    assign bus.rsp_flags = head.flags;

`ifdef FPU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_retired <= '0;
            stat_stall   <= '0;
        end else begin
            if (accept) stat_issued <= stat_issued + 1'b1;
            if (pop) stat_retired <= stat_retired + 1'b1;
            if ((|bus.req_valid) && !accept) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus random traffic, scored
// against a transaction-level queue model and a stub fixed-latency core.
module tb_fpu_issue_ctrl;
    localparam int NCH     = 2;
    localparam int FPU_LAT = 4;
    localparam int RDEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fpu_op;
    logic [1:0]  rmode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] fpu_out;
    logic [7:0]  fpu_flags;
`ifdef FPU_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_retired;
    logic [31:0] stat_stall;
`endif

    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.NCH(NCH)) bus ();

    fpu_issue_ctrl #(.NCH(NCH), .FPU_LAT(FPU_LAT), .RDEPTH(RDEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fpu_op    (fpu_op),
        .rmode     (rmode),
        .opa       (opa),
        .opb       (opb),
        .fpu_out   (fpu_out),
        .fpu_flags (fpu_flags)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_retired (stat_retired),
        .stat_stall   (stat_stall)
`endif
    );

    // Stub core: two known IEEE cases, otherwise an arbitrary but deterministic scramble.
    function automatic logic [39:0] core_fn(input logic [2:0] op, input logic [1:0] rm,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 8'h00};
        if (op == 3'd3 && b == 32'h0) return {32'h7F80_0000, 8'h81};
        return {a ^ {b[15:0], b[31:16]} ^ {27'h0, rm, op}, a[7:0] ^ b[31:24] ^ {op, rm, 3'b000}};
    endfunction

    logic [39:0] core_pipe [FPU_LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(fpu_op, rmode, opa, opb);
        for (int k = 1; k < FPU_LAT - 1; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign {fpu_out, fpu_flags} = core_pipe[FPU_LAT-2];

    typedef struct {
        int          ch;
        logic [31:0] out;
        logic [7:0]  flags;
        int          rdy;
    } exp_t;

    exp_t q[$];
    int   acc_log[$];
    int   rr_m;
    int   ncyc;
    int   acc_cnt;
    int   st_iss, st_ret, st_stall;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic set_req(input int ch, input logic v, input logic [2:0] op, input logic [1:0] rm,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[ch]         = v;
        bus.req_op[3*ch +: 3]     = op;
        bus.req_rmode[2*ch +: 2]  = rm;
        bus.req_opa[32*ch +: 32]  = a;
        bus.req_opb[32*ch +: 32]  = b;
    endtask

    task automatic rand_req(input int ch, input logic v);
        logic [2:0]  op;
        logic [31:0] b;
        op = 3'($urandom_range(0, 3));
        b  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
        set_req(ch, v, op, 2'($urandom_range(0, 3)), 32'($urandom), b);
    endtask

    task automatic model_reset();
        q.delete();
        rr_m     = 0;
        st_iss   = 0;
        st_ret   = 0;
        st_stall = 0;
    endtask

    // One clock: check combinational/registered outputs against the model, then advance it.
    task automatic cycle();
        logic [NCH-1:0] v, exp_rd;
        logic           accept, pop, expv;
        int             w;
        exp_t           e;
        logic [2:0]     aop;
        logic [1:0]     arm;
        logic [31:0]    aa, ab;
        #1;
        v = bus.req_valid;
        w = -1;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (rr_m + i) % NCH;
            if (w < 0 && v[c]) w = c;
        end
        exp_rd = (w >= 0 && q.size() < RDEPTH) ? (NCH'(1) << w) : '0;
        check("req_ready", bus.req_ready, exp_rd);
        expv = (q.size() > 0) && (q[0].rdy <= ncyc);
        check("rsp_valid", bus.rsp_valid, expv);
        if (expv) begin
            check("rsp_ch", bus.rsp_ch, q[0].ch);
            check("rsp_out", bus.rsp_out, q[0].out);
            check("rsp_flags", bus.rsp_flags, q[0].flags);
        end
        accept = (exp_rd != '0);
        pop    = expv && bus.rsp_ready;
        aop = '0; arm = '0; aa = '0; ab = '0;
        if (accept) begin
            aop = bus.req_op[3*w +: 3];
            arm = bus.req_rmode[2*w +: 2];
            aa  = bus.req_opa[32*w +: 32];
            ab  = bus.req_opb[32*w +: 32];
        end
        if (v != '0 && !accept) st_stall++;
        @(posedge clk);
        ncyc++;
        if (pop) begin
            void'(q.pop_front());
            st_ret++;
        end
        if (accept) begin
            {e.out, e.flags} = core_fn(aop, arm, aa, ab);
            e.ch  = w;
            e.rdy = ncyc + FPU_LAT;
            q.push_back(e);
            acc_log.push_back(w);
            rr_m = (w + 1) % NCH;
            st_iss++;
            acc_cnt++;
        end
        @(negedge clk);
        if (accept) begin
            check("fpu_op", fpu_op, aop);
            check("rmode", rmode, arm);
            check("opa", opa, aa);
            check("opb", opb, ab);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_rmode = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        clear_reqs();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() > 0; i++) cycle();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, '0);
        check({tag, "_fpu_op"}, fpu_op, '0);
        check({tag, "_rmode"}, rmode, '0);
        check({tag, "_opa"}, opa, '0);
        check({tag, "_opb"}, opb, '0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_ch"}, bus.rsp_ch, '0);
        check({tag, "_rsp_out"}, bus.rsp_out, '0);
        check({tag, "_rsp_flags"}, bus.rsp_flags, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ncyc = 0;
        acc_cnt = 0;
        rst = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        model_reset();
        bus.req_valid = '1;
        @(negedge clk);
        check_reset_outputs("reset");
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single add on ch0: result visible exactly FPU_LAT edges after accept.
        set_req(0, 1'b1, 3'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000);
        cycle();
        clear_reqs();
        repeat (FPU_LAT) cycle();
        check("add_valid", bus.rsp_valid, 1'b1);
        check("add_ch", bus.rsp_ch, 0);
        check("add_out", bus.rsp_out, 32'h4040_0000);
        check("add_flags", bus.rsp_flags, 8'h00);
        drain();

        // Divide by zero on ch0.
        set_req(0, 1'b1, 3'd3, 2'd0, 32'h3F80_0000, 32'h0000_0000);
        cycle();
        clear_reqs();
        repeat (FPU_LAT) cycle();
        check("div_valid", bus.rsp_valid, 1'b1);
        check("div_out", bus.rsp_out, 32'h7F80_0000);
        check("div_flag_dbz", bus.rsp_flags[7], 1'b1);
        check("div_flag_inf", bus.rsp_flags[0], 1'b1);
        drain();

        // Both channels continuously valid: alternating grants at full rate.
        acc_log.delete();
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            cycle();
        end
        check("rr_accepts", acc_cnt, 8);
        for (int i = 1; i < acc_log.size(); i++)
            check("rr_alternate", acc_log[i], 1 - acc_log[i-1]);
        drain();

        // Backpressure: exactly RDEPTH accepts, then one accept per pop.
        do_reset();
        bus.rsp_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            rand_req(0, 1'b1);
            cycle();
        end
        check("bp_accepts", acc_cnt, RDEPTH);
`ifdef FPU_ISSUE_STATS_EN
        check("stat_issued_bp", stat_issued, RDEPTH);
        check("stat_stall_bp", stat_stall, 14 - RDEPTH);
        check("stat_retired_bp", stat_retired, 0);
`endif
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_req(0, 1'b1);
            cycle();
        end
`ifdef FPU_ISSUE_STATS_EN
        check("stat_issued_rel", stat_issued, st_iss);
        check("stat_retired_rel", stat_retired, st_ret);
        check("stat_stall_rel", stat_stall, st_stall);
`endif
        drain();

        // Reset with three ops in flight discards them.
        for (int i = 0; i < 3; i++) begin
            rand_req(0, 1'b1);
            cycle();
        end
        rand_req(1, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        clear_reqs();
        rst = 1'b0;
        repeat (FPU_LAT + 4) cycle();

        // Random traffic: mostly-ready consumer, then a heavily stalled one.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) rand_req(c, 1'($urandom_range(0, 1)));
            bus.rsp_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain();
`ifdef FPU_ISSUE_STATS_EN
        check("stat_issued_end", stat_issued, st_iss);
        check("stat_retired_end", stat_retired, st_ret);
        check("stat_stall_end", stat_stall, st_stall);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
